// File: rtl/uart_pkg.sv
// uart_pkg: shared UART parity modes, receiver state encoding and parity helper
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} rx_state_t;
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversample tick, one clock wide every DIV clocks
module uart_baud_gen #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_gen: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver with majority vote and valid/ready output
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);
  localparam int H = OVERSAMPLE / 2;
  localparam int SW = $clog2(OVERSAMPLE);
  rx_state_t st, st_n;
  logic [1:0] sync;
  logic [SW-1:0] sc;
  logic [3:0] idx;
  logic [DATA_BITS-1:0] sh;
  logic tick, rx_s, s0, s1, vote, dec, eob, bad;
  logic par_bit, par_err, stop_bad, commit, brk;
  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE)) u_baud (
    .clk(clk), .rst_n(rst_n), .tick(tick)
  );
  assign rx_s = sync[1];
  assign vote = (s0 & s1) | (rx_s & (s0 | s1));
  assign dec  = tick && sc == SW'(H + 1);
  assign eob  = tick && sc == SW'(OVERSAMPLE - 1);
  assign bad  = stop_bad | ~vote;
  always_comb begin
    st_n = st;
    commit = 1'b0;
    brk = 1'b0;
    case (st)
      S_IDLE:   st_n = tick && !rx_s ? S_START : S_IDLE;
      S_START:  st_n = dec && vote ? S_IDLE : eob ? S_DATA : S_START;
      S_DATA:   if (eob && idx == 4'(DATA_BITS - 1)) st_n = PARITY != PAR_NONE ? S_PARITY : S_STOP;
      S_PARITY: if (eob) st_n = S_STOP;
      S_STOP: if (dec && idx == 4'(STOP_BITS - 1)) begin
        // an all-zero frame with a low stop bit is a break, never a word
        brk = bad && sh == '0 && !par_bit;
        commit = !brk;
        st_n = bad ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: if (rx_s) st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= 2'b11;
      st <= S_IDLE;
      sc <= '0;
      idx <= '0;
      sh <= '0;
      s0 <= 1'b1;
      s1 <= 1'b1;
      par_bit <= 1'b0;
      par_err <= 1'b0;
      stop_bad <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      st <= st_n;
      sc <= st == S_IDLE ? '0 : tick ? (eob ? '0 : sc + 1'b1) : sc;
      idx <= st_n != st ? '0 : eob ? idx + 1'b1 : idx;
      if (tick && sc == SW'(H - 1)) s0 <= rx_s;
      if (tick && sc == SW'(H)) s1 <= rx_s;
      if (st == S_DATA && dec) sh <= {vote, sh[DATA_BITS-1:1]};
      if (st == S_IDLE) begin
        par_bit <= 1'b0;
        par_err <= 1'b0;
        stop_bad <= 1'b0;
      end
      if (st == S_PARITY && dec) begin
        par_bit <= vote;
        par_err <= vote ^ parity_bit(9'(sh), PARITY);
      end
      if (st == S_STOP && dec) stop_bad <= bad;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      break_det <= 1'b0;
    end else begin
      overrun <= commit && rx_valid && !rx_ready;
      break_det <= brk;
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data <= sh;
        parity_err <= par_err;
        frame_err <= bad;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench driving 8N1, 8E1 and 7O2 receivers at 16 clocks per bit
module tb_uart_rx_cfg;
  import uart_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_l[3], rdy[3], val[3], pe[3], fe[3], ovr[3], brk[3];
  logic [7:0] dat[3];
  logic [6:0] d2;
  logic [11:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  int n_acc[3] = '{default: 0};
  int n_ovr[3] = '{default: 0};
  int n_brk[3] = '{default: 0};
  always #5 clk = ~clk;
  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .rx_data(dat[0]), .rx_valid(val[0]), .rx_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ovr[0]), .break_det(brk[0]));
  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .rx_data(dat[1]), .rx_valid(val[1]), .rx_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ovr[1]), .break_det(brk[1]));
  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .rx_data(d2), .rx_valid(val[2]), .rx_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ovr[2]), .break_det(brk[2]));
  assign dat[2] = {1'b0, d2};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [15:0] mk(input logic [8:0] d, input int nd, input int pb, input logic [1:0] stp);
    logic [15:0] f;
    int k;
    f = '1;
    f[0] = 1'b0;
    k = 1;
    for (int i = 0; i < nd; i++) begin
      f[k] = d[i];
      k = k + 1;
    end
    if (pb >= 0) begin
      f[k] = pb[0];
      k = k + 1;
    end
    f[k] = stp[0];
    f[k+1] = stp[1];
    return f;
  endfunction
  task automatic send_raw(input int u, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx_l[u] = f[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx_l[u] = 1'b1;
  endtask
  task automatic idle(input int bits);
    repeat (16 * bits) @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n)
      for (int u = 0; u < 3; u++) begin
        if (ovr[u]) n_ovr[u]++;
        if (brk[u]) n_brk[u]++;
        if (val[u] && rdy[u]) begin
          n_acc[u]++;
          if (exp_q.size() == 0) check("word_expected", 32'(exp_q.size()), 1);
          else check("word", {2'(u), pe[u], fe[u], dat[u]}, exp_q.pop_front());
        end
      end
  initial begin
    for (int u = 0; u < 3; u++) begin
      rx_l[u] = 1'b1;
      rdy[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", val[0], 0);
    check("rst_data", dat[0], 0);
    check("rst_perr", pe[1], 0);
    check("rst_ferr", fe[2], 0);
    check("rst_ovr", ovr[0], 0);
    check("rst_brk", brk[0], 0);
    rst_n = 1'b1;
    idle(2);
    exp_q.push_back({2'd0, 2'b00, 8'hA5});
    send_raw(0, mk(9'hA5, 8, -1, 2'b11), 10);
    idle(2);
    check("a5_accepts", n_acc[0], 1);
    check("a5_drained", exp_q.size(), 0);
    exp_q.push_back({2'd1, 2'b10, 8'h03});
    send_raw(1, mk(9'h03, 8, 1, 2'b11), 11);
    exp_q.push_back({2'd1, 2'b00, 8'h03});
    send_raw(1, mk(9'h03, 8, 0, 2'b11), 11);
    idle(2);
    check("par_accepts", n_acc[1], 2);
    exp_q.push_back({2'd2, 2'b01, 8'h55});
    send_raw(2, mk(9'h55, 7, 1, 2'b01), 11);
    idle(2);
    exp_q.push_back({2'd2, 2'b00, 8'h12});
    send_raw(2, mk(9'h12, 7, 1, 2'b11), 11);
    idle(2);
    check("frm_accepts", n_acc[2], 2);
    check("frm_drained", exp_q.size(), 0);
    rx_l[0] = 1'b0;
    repeat (320) @(posedge clk);
    #1;
    rx_l[0] = 1'b1;
    idle(2);
    check("brk_pulses", n_brk[0], 1);
    check("brk_no_word", n_acc[0], 1);
    exp_q.push_back({2'd0, 2'b00, 8'h3C});
    send_raw(0, mk(9'h3C, 8, -1, 2'b11), 10);
    idle(2);
    check("post_brk_accepts", n_acc[0], 2);
    rdy[0] = 1'b0;
    send_raw(0, mk(9'h11, 8, -1, 2'b11), 10);
    send_raw(0, mk(9'h22, 8, -1, 2'b11), 10);
    check("ovr_hold_data", dat[0], 8'h11);
    check("ovr_hold_valid", val[0], 1);
    check("ovr_pulses", n_ovr[0], 1);
    exp_q.push_back({2'd0, 2'b00, 8'h11});
    exp_q.push_back({2'd0, 2'b00, 8'h33});
    fork
      send_raw(0, mk(9'h33, 8, -1, 2'b11), 10);
      begin
        repeat (156) @(posedge clk);
        #1;
        rdy[0] = 1'b1;
      end
    join
    idle(1);
    check("ovr_no_new", n_ovr[0], 1);
    check("ovr_accepts", n_acc[0], 4);
    check("ovr_valid_clear", val[0], 0);
    rx_l[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx_l[0] = 1'b1;
    idle(2);
    check("glitch_state", dut0.st, S_IDLE);
    check("glitch_no_word", n_acc[0], 4);
    rdy[0] = 1'b0;
    send_raw(0, mk(9'h5A, 8, -1, 2'b11), 10);
    check("held_5a", dat[0], 8'h5A);
    send_raw(0, mk(9'hF0, 8, -1, 2'b11), 4);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", val[0], 0);
    check("rst_mid_data", dat[0], 0);
    check("rst_mid_state", dut0.st, S_IDLE);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy[0] = 1'b1;
    exp_q.push_back({2'd0, 2'b00, 8'h7E});
    send_raw(0, mk(9'h7E, 8, -1, 2'b11), 10);
    idle(2);
    check("final_drained", exp_q.size(), 0);
    check("final_accepts", n_acc[0], 5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
